// File: rtl/store_lane_writer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// store_lane_writer_if : store request / data-memory handshake bundle  rev 1.0
// ---------------------------------------------------------------------------
interface store_lane_writer_if;
  logic        St_Valid;
  logic        St_Ready;
  logic [31:0] St_Addr;
  logic [31:0] St_Data;
  logic [1:0]  St_Size;
  logic        St_Done;
  logic        St_Err;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic [3:0]  Mem_BE;
  logic        Mem_Ack;

  // Environment side: upstream pipeline stage plus data memory
  modport master (
    output St_Valid, St_Addr, St_Data, St_Size, Mem_Ack,
    input  St_Ready, St_Done, St_Err, Mem_Req, Mem_Addr, Mem_WData, Mem_BE
  );

  // Store write stage
  modport slave (
    input  St_Valid, St_Addr, St_Data, St_Size, Mem_Ack,
    output St_Ready, St_Done, St_Err, Mem_Req, Mem_Addr, Mem_WData, Mem_BE
  );
endinterface
`default_nettype wire

// File: rtl/store_lane_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// store_lane_writer : lane-aligned store with req/ack and timeout;
// MISALIGN_TRAP_EN turns misaligned/reserved stores into errors.    rev 1.0
// ---------------------------------------------------------------------------
module store_lane_writer #(
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 8
) (
  input  wire logic          CLK,
  input  wire logic          RST_n,
  store_lane_writer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             ready;
  logic             trap;
  logic [31:0]      lane_wdata;
  logic [3:0]       lane_be;

  assign ready = RST_n && (state_q == S_IDLE);

`ifdef MISALIGN_TRAP_EN
  assign trap = (bus.St_Size == 2'b11)
             || ((bus.St_Size == 2'b01) && bus.St_Addr[0])
             || ((bus.St_Size == 2'b10) && (bus.St_Addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Without the trap, dropping the low address bits is what forces natural alignment
  always_comb begin
    lane_wdata = bus.St_Data;
    lane_be    = 4'b1111;
    case (bus.St_Size)
      2'b00: begin
        lane_wdata = {24'b0, bus.St_Data[7:0]} << {bus.St_Addr[1:0], 3'b000};
        lane_be    = 4'b0001 << bus.St_Addr[1:0];
      end
      2'b01: begin
        if (bus.St_Addr[1]) begin
          lane_wdata = {bus.St_Data[15:0], 16'b0};
          lane_be    = 4'b1100;
        end else begin
          lane_wdata = {16'b0, bus.St_Data[15:0]};
          lane_be    = 4'b0011;
        end
      end
      default: begin
        lane_wdata = bus.St_Data;
        lane_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.St_Valid && ready) begin
          if (trap) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            cnt_d   = '0;
            addr_d  = {bus.St_Addr[31:2], 2'b00};
            wdata_d = lane_wdata;
            be_d    = lane_be;
          end
        end
      end
      S_REQ: begin
        // Ack takes priority over a timeout landing on the same edge
        if (bus.Mem_Ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_ERR;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.St_Ready  = ready;
  assign bus.St_Done   = done_q;
  assign bus.St_Err    = err_q;
  assign bus.Mem_Req   = req_q;
  assign bus.Mem_Addr  = addr_q;
  assign bus.Mem_WData = wdata_q;
  assign bus.Mem_BE    = be_q;

endmodule
`default_nettype wire

// File: tb/tb_store_lane_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_store_lane_writer : vector table, directed corners and random stores  rev 1.0
// ---------------------------------------------------------------------------
module tb_store_lane_writer;
  localparam int TO = 15;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_lane_writer_if bus ();

  store_lane_writer #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    int          dly;
    logic [31:0] ea;
    logic [31:0] ew;
    logic [3:0]  ebe;
    bit          trap;
  } vec_t;

  vec_t tbl [7];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a store of nb bytes lands at byte offset off, masked to nb bytes
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                                output logic [31:0] ea, output logic [31:0] ew,
                                output logic [3:0] ebe, output bit trap);
    int          nb;
    int          off;
    logic [63:0] m;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off  = int'(a[1:0]);
    trap = TRAP && ((sz == 2'd3) || ((off % nb) != 0));
    off  = off - (off % nb);
    m    = (64'd1 << (8 * nb)) - 64'd1;
    ew   = 32'((64'(d) & m) << (8 * off));
    ebe  = 4'(((1 << nb) - 1) << off);
    ea   = a & 32'hFFFF_FFFC;
  endfunction

  // dly: REQ cycle index (0-based) in which Mem_Ack is raised; <0 or >=TO never acks
  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input int dly, input logic [31:0] ea, input logic [31:0] ew,
                           input logic [3:0] ebe, input bit etrap);
    int w;
    bit acked;
    w = 0;
    while (!bus.St_Ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk1("ready_before_accept", bus.St_Ready, 1'b1);
    bus.St_Valid = 1'b1;
    bus.St_Addr  = a;
    bus.St_Data  = d;
    bus.St_Size  = sz;
    @(posedge clk); #1;
    bus.St_Valid = 1'b0;
    if (etrap) begin
      chk1("trap_req_low", bus.Mem_Req, 1'b0);
      chk1("trap_err", bus.St_Err, 1'b1);
      chk1("trap_no_done", bus.St_Done, 1'b0);
      chk1("trap_not_ready", bus.St_Ready, 1'b0);
      @(posedge clk); #1;
      chk1("trap_err_one_cycle", bus.St_Err, 1'b0);
      chk1("trap_ready_again", bus.St_Ready, 1'b1);
    end else begin
      acked = 1'b0;
      for (int k = 0; k < TO && !acked; k++) begin
        chk1("req_high", bus.Mem_Req, 1'b1);
        chk32("mem_addr", bus.Mem_Addr, ea);
        chk32("mem_wdata", bus.Mem_WData, ew);
        chk32("mem_be", 32'(bus.Mem_BE), 32'(ebe));
        chk1("no_done_in_req", bus.St_Done, 1'b0);
        chk1("not_ready_in_req", bus.St_Ready, 1'b0);
        bus.Mem_Ack = (k == dly);
        @(posedge clk); #1;
        if (bus.Mem_Ack) begin
          acked = 1'b1;
          bus.Mem_Ack = 1'b0;
          chk1("done_pulse", bus.St_Done, 1'b1);
          chk1("no_err_on_ack", bus.St_Err, 1'b0);
          chk1("req_low_after_ack", bus.Mem_Req, 1'b0);
          chk1("ready_with_done", bus.St_Ready, 1'b1);
        end
      end
      if (!acked) begin
        chk1("timeout_req_low", bus.Mem_Req, 1'b0);
        chk1("timeout_err", bus.St_Err, 1'b1);
        chk1("timeout_no_done", bus.St_Done, 1'b0);
        chk1("timeout_not_ready", bus.St_Ready, 1'b0);
        @(posedge clk); #1;
        chk1("timeout_err_one_cycle", bus.St_Err, 1'b0);
        chk1("timeout_ready_again", bus.St_Ready, 1'b1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rd, ea, ew;
    logic [1:0]  rs;
    logic [3:0]  ebe;
    bit          etrap;
    int          rdly;

    tbl[0] = '{32'h0000_1003, 32'hAABB_CCDD, 2'b00, 0,      32'h0000_1000, 32'hDD00_0000, 4'b1000, 1'b0};
    tbl[1] = '{32'h0000_2002, 32'h0000_1234, 2'b01, 2,      32'h0000_2000, 32'h1234_0000, 4'b1100, 1'b0};
    tbl[2] = '{32'h0000_0040, 32'h1122_3344, 2'b10, -1,     32'h0000_0040, 32'h1122_3344, 4'b1111, 1'b0};
    tbl[3] = '{32'h0000_0080, 32'h5566_7788, 2'b10, TO - 1, 32'h0000_0080, 32'h5566_7788, 4'b1111, 1'b0};
    tbl[4] = '{32'h0000_0005, 32'hCAFE_F00D, 2'b10, 1,      32'h0000_0004, 32'hCAFE_F00D, 4'b1111, TRAP};
    tbl[5] = '{32'h0000_0301, 32'h1111_BEEF, 2'b01, 0,      32'h0000_0300, 32'h0000_BEEF, 4'b0011, TRAP};
    tbl[6] = '{32'hF000_0102, 32'h0000_005A, 2'b00, 1,      32'hF000_0100, 32'h005A_0000, 4'b0100, 1'b0};

    bus.St_Valid = 1'b0;
    bus.St_Addr  = '0;
    bus.St_Data  = '0;
    bus.St_Size  = '0;
    bus.Mem_Ack  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_ready", bus.St_Ready, 1'b0);
    chk1("rst_req", bus.Mem_Req, 1'b0);
    chk32("rst_addr", bus.Mem_Addr, 32'h0);
    chk32("rst_wdata", bus.Mem_WData, 32'h0);
    chk32("rst_be", 32'(bus.Mem_BE), 32'h0);
    chk1("rst_done", bus.St_Done, 1'b0);
    chk1("rst_err", bus.St_Err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("ready_after_rst", bus.St_Ready, 1'b1);

    // Ack with no request outstanding must do nothing
    bus.Mem_Ack = 1'b1;
    @(posedge clk); #1;
    bus.Mem_Ack = 1'b0;
    chk1("idle_ack_no_done", bus.St_Done, 1'b0);
    chk1("idle_ack_no_req", bus.Mem_Req, 1'b0);

    for (int i = 0; i < 7; i++)
      run_store(tbl[i].a, tbl[i].d, tbl[i].sz, tbl[i].dly,
                tbl[i].ea, tbl[i].ew, tbl[i].ebe, tbl[i].trap);

    // Reset in the second REQ cycle drops the store
    bus.St_Valid = 1'b1;
    bus.St_Addr  = 32'h0000_1003;
    bus.St_Data  = 32'hAABB_CCDD;
    bus.St_Size  = 2'b00;
    @(posedge clk); #1;
    bus.St_Valid = 1'b0;
    @(posedge clk); #1;
    chk1("mid_req_high", bus.Mem_Req, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk1("midrst_req", bus.Mem_Req, 1'b0);
    chk32("midrst_addr", bus.Mem_Addr, 32'h0);
    chk32("midrst_wdata", bus.Mem_WData, 32'h0);
    chk32("midrst_be", 32'(bus.Mem_BE), 32'h0);
    chk1("midrst_done", bus.St_Done, 1'b0);
    chk1("midrst_err", bus.St_Err, 1'b0);
    chk1("midrst_ready", bus.St_Ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("postrst_ready", bus.St_Ready, 1'b1);
    chk1("postrst_done", bus.St_Done, 1'b0);
    chk1("postrst_err", bus.St_Err, 1'b0);
    chk1("postrst_req", bus.Mem_Req, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra   = $urandom;
      rd   = $urandom;
      rs   = 2'($urandom_range(0, 3));
      rdly = int'($urandom_range(0, TO + 1));
      model(ra, rd, rs, ea, ew, ebe, etrap);
      run_store(ra, rd, rs, rdly, ea, ew, ebe, etrap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/store_lane_writer.md
Name: store_lane_writer

Overview:
Store-side write stage placed between the execute/memory pipeline stage and the data-memory port. It accepts one store request (address, data, size) per handshake and places the byte, halfword or word on the correct 32-bit lane or lanes. It generates byte enables and holds a request/acknowledge transaction toward data memory, with a timeout. The lane-placement rule is the same as the existing byte-lane store mux: selected data in its lane, all other lanes zero.

Parameters:
TIMEOUT_CYC, 15, number of REQ cycles without Mem_Ack before the access is abandoned (legal range 2..255)
CNT_W, 8, width of the timeout counter (must hold TIMEOUT_CYC)

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST_n  input  1  synchronous, active-low reset
St_Valid  input  1  store request valid
St_Ready  output  1  stage can accept a request (high only in IDLE and not in reset)
St_Addr  input  32  byte address of the store
St_Data  input  32  store data, right-justified (byte in [7:0], half in [15:0])
St_Size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved
St_Done  output  1  one-cycle pulse: store committed to memory
St_Err  output  1  one-cycle pulse: store abandoned (timeout, or misaligned with trap enabled)
Mem_Req  output  1  memory write request, registered
Mem_Addr  output  32  word address ({St_Addr[31:2], 2'b00}), registered
Mem_WData  output  32  lane-aligned write data, registered
Mem_BE  output  4  byte enables, bit i = lane i (bits [8i+7:8i]), registered
Mem_Ack  input  1  memory accepted the write; sampled only while Mem_Req = 1

Behaviour:
- Reset (RST_n = 0 at an edge): state goes to IDLE. Mem_Req, Mem_Addr, Mem_WData, Mem_BE, St_Done, St_Err and the timeout counter all go to 0. St_Ready = 0 while RST_n is low.
- Reset during REQ drops the in-flight store. No St_Done or St_Err is produced, and Mem_Req is 0 after the edge.
- FSM states: IDLE, REQ, ERR.
- IDLE: St_Ready = 1. When St_Valid & St_Ready at edge N, capture the request, load Mem_Addr/Mem_WData/Mem_BE, set Mem_Req = 1, clear the counter and go to REQ. Outputs are visible after edge N.
- Lane placement uses a = St_Addr[1:0]:
  - Byte: WData = St_Data[7:0] shifted to lane a, other lanes 0. BE = 4'b0001 << a.
  - Half: a[1] = 0 gives WData = {16'b0, St_Data[15:0]}, BE = 0011. a[1] = 1 gives WData = {St_Data[15:0], 16'b0}, BE = 1100.
  - Word: WData = St_Data, BE = 1111.
- Misaligned cases: half with a[0] = 1, word with a != 0, and any St_Size = 11. Handling is defined under Optional Feature.
- REQ: Mem_Req = 1. Mem_Addr, Mem_WData and Mem_BE stay stable until Mem_Req falls.
  - Mem_Ack = 1 at an edge: Mem_Req = 0, St_Done = 1 for exactly one cycle, go to IDLE. St_Ready is high in the same cycle as St_Done.
  - Otherwise the counter increments. If Mem_Ack = 0 when counter = TIMEOUT_CYC-1, go to ERR and set Mem_Req = 0.
  - Ack in the same cycle as the timeout: the ack wins and St_Done is produced, not St_Err.
- ERR: St_Err = 1 for one cycle, then unconditionally go to IDLE. St_Ready = 0 while in ERR.
- Minimum latency from accept to St_Done is 1 cycle (ack in the first REQ cycle). Peak throughput is one store per 2 cycles.
- St_Valid while not ready: the request is ignored. The upstream stage must hold it stable until accepted.
- Mem_Ack while Mem_Req = 0 is ignored.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined: a misaligned or reserved-size request is accepted but issues no memory access. Mem_Req stays 0 and the FSM goes IDLE to ERR, so St_Err pulses in the cycle after accept.
- Not defined: the address is forced to natural alignment (half: a[0] = 0; word: a = 00), size 11 is treated as word, and the store proceeds normally. St_Err then comes only from timeout.

Test Plan:
- Byte store: Addr = 0x1003, Data = 0xAABBCCDD, Size = 00, Ack in the 1st REQ cycle -> Mem_Addr = 0x1000, WData = 0xDD000000, BE = 1000, St_Done one cycle after accept.
- Half store: Addr = 0x2002, Data = 0x00001234, Size = 01, Ack after 3 REQ cycles -> WData = 0x12340000, BE = 1100, outputs stable across all 3 cycles, St_Done once.
- Timeout: word store to 0x40 with Ack held low, TIMEOUT_CYC = 15 -> Mem_Req high for 15 cycles, then low. St_Err pulses once, St_Done never.
- Ack on the final timeout cycle -> St_Done = 1, St_Err = 0.
- Misaligned word, Addr = 0x0005, Data = 0xCAFEF00D:
  - With MISALIGN_TRAP_EN: Mem_Req never rises, St_Err one cycle after accept.
  - Without: Mem_Addr = 0x0004, WData = 0xCAFEF00D, BE = 1111, St_Done.
- Reset: RST_n low in the 2nd REQ cycle -> Mem_Req = 0 and all outputs 0 after the edge, no Done/Err. St_Ready returns to 1 at the first edge with RST_n high.
